// File: rtl/branch_repair_unit_pkg.sv
// Shared types for the branch repair unit: repair action bits, FSM states,
// the queued repair record and the mispredict rule.
package branch_repair_unit_pkg;

    localparam int SINGLE_WORD     = 32;
    localparam int REPAIR_ACTION_W = 4;
    localparam int NEED_REPAIR     = 0;
    localparam int BTB_ACTION      = 1;
    localparam int PHT_ACTION      = 2;
    localparam int IJTC_ACTION     = 3;

    typedef logic [REPAIR_ACTION_W-1:0] repair_action_t;

    localparam repair_action_t BTB_REPAIR_ACTION =
        repair_action_t'((1 << NEED_REPAIR) | (1 << BTB_ACTION));

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_DS = 2'd1,
        REDIR   = 2'd2
    } brs_state_t;

    typedef struct packed {
        logic [SINGLE_WORD-1:0] vaddr;
        logic                   take;
        logic [SINGLE_WORD-1:0] dest;
    } repair_rec_t;

    // Not-taken predictions carry the sequential address as dest, so dest
    // only matters when the branch was actually taken.
    function automatic logic is_mispredict(
        input logic                   valid,
        input logic                   pred_take,
        input logic                   act_take,
        input logic [SINGLE_WORD-1:0] pred_dest,
        input logic [SINGLE_WORD-1:0] act_dest
    );
        return valid && ((pred_take != act_take) || (act_take && (pred_dest != act_dest)));
    endfunction

endpackage

// File: rtl/branch_repair_unit_repair_fifo.sv
// Synchronous FIFO with a registered head word; supports push and pop in the
// same cycle, including when full.
module repair_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg, rd_ptr_next;
    logic [OCC_W-1:0] count_reg, count_next, remain;
    logic [WIDTH-1:0] head_reg, head_next;
    logic             valid_reg;
    logic             full, empty, push_ok, pop_ok;

    assign full    = (count_reg == OCC_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && full && !pop_ok;

    assign count_next  = count_reg + OCC_W'(push_ok) - OCC_W'(pop_ok);
    assign remain      = count_reg - OCC_W'(pop_ok);
    assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop_ok);

    // When no older entry survives the pop, the incoming word becomes the head.
    always_comb begin
        head_next = '0;
        if (count_next != '0) begin
            if (remain == '0) head_next = din;
            else              head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
            valid_reg  <= 1'b0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(push_ok);
            count_reg  <= count_next;
            head_reg   <= head_next;
            valid_reg  <= (count_next != '0);
        end
    end

    assign head  = head_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/branch_repair_unit.sv
// Resolve-side BTB repair: detects mispredicts, queues BTB repair records and
// issues one fetch redirect once the delay slot is in the backend.
module branch_repair_unit
    import branch_repair_unit_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       BR_valid_i,
    input  logic [63:0]      BR_VAddr_p_i,
    input  logic [1:0]       BR_predTake_i,
    input  logic [63:0]      BR_predDest_p_i,
    input  logic [1:0]       BR_actTake_i,
    input  logic [63:0]      BR_actDest_p_i,
    input  logic [1:0]       BR_dsIn_i,
    input  logic             DS_arrive_i,
    input  logic             CP0_flush_i,
    input  logic             BTB_repairReady_i,
    output logic [3:0]       FU_repairAction_w_o,
    output logic [31:0]      FU_erroVAddr_w_o,
    output logic             FU_correctTake_w_o,
    output logic [31:0]      FU_correctDest_w_o,
    output logic             FU_redirect_o,
    output logic [31:0]      FU_redirectVAddr_o,
    output logic [CNT_W-1:0] FU_dropCnt_o
);

    logic [1:0]  mp;
    logic [31:0] port_vaddr [2];
    logic [31:0] port_dest  [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign port_vaddr[gi] = BR_VAddr_p_i[32*gi +: 32];
            assign port_dest[gi]  = BR_actDest_p_i[32*gi +: 32];
            assign mp[gi] = is_mispredict(BR_valid_i[gi], BR_predTake_i[gi], BR_actTake_i[gi],
                                          BR_predDest_p_i[32*gi +: 32], port_dest[gi]);
        end
    endgenerate

    brs_state_t  state_reg;
    logic        sel, sel_take, sel_ds, accept;
    logic [31:0] sel_vaddr, sel_dest, new_target;

    // Port 0 is older, so it wins whenever it mispredicts.
    assign sel        = !mp[0];
    assign sel_vaddr  = sel ? port_vaddr[1] : port_vaddr[0];
    assign sel_dest   = sel ? port_dest[1]  : port_dest[0];
    assign sel_take   = sel ? BR_actTake_i[1] : BR_actTake_i[0];
    assign sel_ds     = sel ? BR_dsIn_i[1]    : BR_dsIn_i[0];
    assign accept     = (state_reg == IDLE) && (mp != 2'b00);
    assign new_target = sel_take ? sel_dest : (sel_vaddr + 32'd8);

    logic [31:0] target_reg;
    logic        redirect_reg;
    logic [31:0] redirect_vaddr_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg          <= IDLE;
            target_reg         <= '0;
            redirect_reg       <= 1'b0;
            redirect_vaddr_reg <= '0;
        end else begin
            redirect_reg       <= 1'b0;
            redirect_vaddr_reg <= '0;
            if (CP0_flush_i) begin
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: if (accept) begin
                        target_reg <= new_target;
                        if (sel_ds) begin
                            state_reg          <= REDIR;
                            redirect_reg       <= 1'b1;
                            redirect_vaddr_reg <= new_target;
                        end else begin
                            state_reg <= WAIT_DS;
                        end
                    end
                    WAIT_DS: if (DS_arrive_i) begin
                        state_reg          <= REDIR;
                        redirect_reg       <= 1'b1;
                        redirect_vaddr_reg <= target_reg;
                    end
                    REDIR:   state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    repair_rec_t enq_rec, head_rec;
    logic        fifo_valid, fifo_pop, fifo_drop;

    assign enq_rec.vaddr = sel_vaddr;
    assign enq_rec.take  = sel_take;
    assign enq_rec.dest  = sel_dest;
    assign fifo_pop      = fifo_valid && BTB_repairReady_i;

    repair_fifo #(
        .WIDTH($bits(repair_rec_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (accept),
        .din  (enq_rec),
        .pop  (fifo_pop),
        .head (head_rec),
        .valid(fifo_valid),
        .drop (fifo_drop)
    );

    logic [CNT_W-1:0] drop_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                 drop_cnt_reg <= '0;
        else if (fifo_drop && (drop_cnt_reg != '1)) drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end

    assign FU_repairAction_w_o = fifo_valid ? BTB_REPAIR_ACTION : '0;
    assign FU_erroVAddr_w_o    = head_rec.vaddr;
    assign FU_correctTake_w_o  = head_rec.take;
    assign FU_correctDest_w_o  = head_rec.dest;
    assign FU_redirect_o       = redirect_reg;
    assign FU_redirectVAddr_o  = redirect_vaddr_reg;
    assign FU_dropCnt_o        = drop_cnt_reg;

endmodule
